// File: rtl/serial_frame_rx_if.sv
// Serial receiver bus: line input plus the valid/ready word output and error pulses.
interface serial_frame_rx_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic              din;
  logic [DATA_W-1:0] data_out;
  logic              valid;
  logic              ready;
  logic              frame_err;
  logic              overrun;

  modport master (
    input  din,
    input  ready,
    output data_out,
    output valid,
    output frame_err,
    output overrun
  );

  modport slave (
    output din,
    output ready,
    input  data_out,
    input  valid,
    input  frame_err,
    input  overrun
  );
endinterface

// File: rtl/serial_frame_rx.sv
// Start/stop framed serial receiver with mid-bit sampling and a one-entry
// valid/ready output buffer; flags bad stop bits and words dropped on stall.
module serial_frame_rx #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic               clk,
  input  logic               rst,
  serial_frame_rx_if.master  bus
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                sync1_q, sync2_q;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                complete_q, complete_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                valid_q, valid_d;
  logic                frame_err_q, frame_err_d;
  logic                overrun_q, overrun_d;
  logic                din_s;

  assign din_s = sync2_q;

  // Line synchronizer idles high so reset never looks like a start bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= bus.din;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      complete_q  <= 1'b0;
      data_out_q  <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      complete_q  <= complete_d;
      data_out_q  <= data_out_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    complete_d  = 1'b0;
    frame_err_d = 1'b0;
    data_out_d  = data_out_q;
    valid_d     = valid_q;
    overrun_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!din_s) begin
          state_d   = START;
          bit_cnt_d = '0;
        end
      end
      // Half-bit check rejects glitches and aligns later samples to mid-bit
      START: begin
        if (bit_cnt_q == HALF_M1) begin
          bit_cnt_d = '0;
          if (!din_s) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_cnt_q == FULL_M1) begin
          bit_cnt_d      = '0;
          shift_d[idx_q] = din_s;
          if (idx_q == LAST_IDX) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_cnt_q == FULL_M1) begin
          bit_cnt_d = '0;
          if (din_s) begin
            state_d    = IDLE;
            complete_d = 1'b1;
          end else begin
            state_d     = BRK;
            frame_err_d = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      // A held-low line must go idle before another start is accepted
      BRK: begin
        if (din_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Output buffer: a completed word replaces a consumed one, else it is dropped
    if (complete_q) begin
      if (!valid_q || bus.ready) begin
        data_out_d = shift_q;
        valid_d    = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && bus.ready) begin
      valid_d = 1'b0;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;

endmodule
